// File: rtl/present_pkg.sv
// Shared types, constants and helper functions for the iterative 16-bit PRESENT-style cipher.
// Holds the S-box tables, bit permutations, key schedule steps and the controller state enum.
package present_pkg;

    localparam int BLOCK_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENC    = 3'd1,
        WHITE  = 3'd2,
        KEYFWD = 3'd3,
        DWHITE = 3'd4,
        DEC    = 3'd5,
        DONE   = 3'd6
    } state_e;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [BLOCK_W-1:0] sub_layer(input logic [BLOCK_W-1:0] x);
        return {SBOX[x[15:12]], SBOX[x[11:8]], SBOX[x[7:4]], SBOX[x[3:0]]};
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sub_layer(input logic [BLOCK_W-1:0] x);
        return {SBOX_INV[x[15:12]], SBOX_INV[x[11:8]], SBOX_INV[x[7:4]], SBOX_INV[x[3:0]]};
    endfunction

    // Bit i lands on (4*i) mod 15; bit 15 never moves.
    function automatic logic [BLOCK_W-1:0] perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            y[4'((4 * i) % 15)] = x[4'(i)];
        end
        y[15] = x[15];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            y[4'(i)] = x[4'((4 * i) % 15)];
        end
        y[15] = x[15];
        return y;
    endfunction

    function automatic logic [31:0] key_update(input logic [31:0] k, input logic [3:0] rc);
        logic [31:0] t;
        t        = {k[23:0], k[31:24]};
        t[31:28] = SBOX[t[31:28]];
        t[7:4]   = t[7:4] ^ rc;
        return t;
    endfunction

    function automatic logic [31:0] key_update_inv(input logic [31:0] k, input logic [3:0] rc);
        logic [31:0] t;
        t        = k;
        t[7:4]   = t[7:4] ^ rc;
        t[31:28] = SBOX_INV[t[31:28]];
        return {t[7:0], t[31:8]};
    endfunction

endpackage

// File: rtl/present_round_dp.sv
// Single combinational round: forward (key add, S-box, permute) or inverse
// (inverse permute, inverse S-box, key add) selected by inv_i.
module present_round_dp
    import present_pkg::*;
(
    input  logic               inv_i,
    input  logic [BLOCK_W-1:0] s_i,
    input  logic [BLOCK_W-1:0] rk_i,
    output logic [BLOCK_W-1:0] s_o
);

    // Round datapath selected by direction
    always_comb begin
        s_o = s_i;
        if (inv_i) begin
            s_o = inv_sub_layer(inv_perm(s_i)) ^ rk_i;
        end else begin
            s_o = perm(sub_layer(s_i ^ rk_i));
        end
    end

endmodule

// File: rtl/present_iter_ctrl.sv
// Iterative PRESENT-style encrypt/decrypt controller with a valid/ready host interface.
// Optional decrypt key-schedule cache enabled by defining PRESENT_KEYCACHE_EN.
module present_iter_ctrl
    import present_pkg::*;
#(
    parameter int ROUNDS = 7,
    parameter int KEY_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [BLOCK_W-1:0] in_text,
    input  logic [KEY_W-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_text,
    output logic               busy
);

    localparam logic [3:0] RC_LAST = 4'(ROUNDS);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] s_q, s_d;
    logic [KEY_W-1:0]   k_q, k_d;
    logic [KEY_W-1:0]   kp_s;
    logic [3:0]         rc_q, rc_d;
    logic [BLOCK_W-1:0] rk_s;
    logic [BLOCK_W-1:0] dp_s;
    logic               dp_inv_s;
    logic               in_ready_q, busy_q, out_valid_q;
    logic [BLOCK_W-1:0] out_text_q;

`ifdef PRESENT_KEYCACHE_EN
    logic               cache_vld_q;
    logic [KEY_W-1:0]   cache_mk_q, cache_kf_q, mk_q;
    logic               cache_hit_s;

    assign cache_hit_s = cache_vld_q && (in_key == cache_mk_q);
`endif

    present_round_dp u_round_dp (
        .inv_i (dp_inv_s),
        .s_i   (s_q),
        .rk_i  (rk_s),
        .s_o   (dp_s)
    );

    // Next-state, datapath and key schedule control
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        k_d      = k_q;
        rc_d     = rc_q;
        dp_inv_s = 1'b0;
        kp_s     = key_update_inv(k_q, rc_q);
        rk_s     = k_q[31:16];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d  = in_text;
                    k_d  = in_key;
                    rc_d = 4'd1;
                    if (in_mode) begin
`ifdef PRESENT_KEYCACHE_EN
                        if (cache_hit_s) begin
                            k_d     = cache_kf_q;
                            rc_d    = RC_LAST;
                            state_d = DWHITE;
                        end else begin
                            state_d = KEYFWD;
                        end
`else
                        state_d = KEYFWD;
`endif
                    end else begin
                        state_d = ENC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ENC: begin
                s_d = dp_s;
                k_d = key_update(k_q, rc_q);
                if (rc_q == RC_LAST) begin
                    state_d = WHITE;
                end else begin
                    rc_d = rc_q + 4'd1;
                end
            end
            WHITE: begin
                s_d     = s_q ^ k_q[31:16];
                state_d = DONE;
            end
            KEYFWD: begin
                k_d = key_update(k_q, rc_q);
                // rc stays at ROUNDS on exit so DEC can walk it back down
                if (rc_q == RC_LAST) begin
                    state_d = DWHITE;
                end else begin
                    rc_d = rc_q + 4'd1;
                end
            end
            DWHITE: begin
                s_d     = s_q ^ k_q[31:16];
                state_d = DEC;
            end
            DEC: begin
                dp_inv_s = 1'b1;
                rk_s     = kp_s[31:16];
                s_d      = dp_s;
                k_d      = kp_s;
                if (rc_q == 4'd1) begin
                    state_d = DONE;
                end else begin
                    rc_d = rc_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered host-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            k_q         <= '0;
            rc_q        <= 4'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_text_q  <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            rc_q        <= rc_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == DONE);
            out_text_q  <= (state_d == DONE) ? s_d : '0;
        end
    end

`ifdef PRESENT_KEYCACHE_EN
    // Remember the master key of a missed decrypt and its fully scheduled key
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_mk_q  <= '0;
            cache_kf_q  <= '0;
            mk_q        <= '0;
        end else begin
            if (state_q == IDLE && in_valid && in_mode) begin
                mk_q <= in_key;
            end
            if (state_q == KEYFWD && rc_q == RC_LAST) begin
                cache_vld_q <= 1'b1;
                cache_mk_q  <= mk_q;
                cache_kf_q  <= k_d;
            end
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_text  = out_text_q;

endmodule

// File: tb/tb_present_iter_ctrl.sv
// Randomized self-checking bench for present_iter_ctrl against a round-key-list cipher model.
module tb_present_iter_ctrl;
    localparam int R = 7;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_mode, out_ready;
    logic        in_ready, out_valid, busy;
    logic [15:0] in_text, out_text;
    logic [31:0] in_key;

    int checks = 0;
    int failures = 0;
    bit c_vld = 1'b0;
    logic [31:0] c_key = 32'h0;
    int SB [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    present_iter_ctrl #(.ROUNDS(R), .KEY_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_text(in_text), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_sub(input int x, input bit inv);
        int y = 0;
        for (int n = 0; n < 4; n++) begin
            int v = (x >> (4 * n)) & 15;
            int w = SB[v];
            if (inv) begin
                for (int j = 0; j < 16; j++) if (SB[j] == v) w = j;
            end
            y |= w << (4 * n);
        end
        return y;
    endfunction

    function automatic int m_perm(input int x, input bit inv);
        int y = x & 32'h8000;
        for (int i = 0; i < 15; i++) begin
            int p = (4 * i) % 15;
            if (!inv && ((x >> i) & 1) != 0) y |= 1 << p;
            if (inv && ((x >> p) & 1) != 0) y |= 1 << i;
        end
        return y;
    endfunction

    // Round keys rk[0..R] from the forward schedule only
    task automatic m_keys(input logic [31:0] key, output int rk [R+1]);
        logic [31:0] k = key;
        rk[0] = int'(k[31:16]);
        for (int r = 1; r <= R; r++) begin
            k = {k[23:0], k[31:24]};
            k[31:28] = 4'(SB[k[31:28]]);
            k[7:4] = k[7:4] ^ 4'(r);
            rk[r] = int'(k[31:16]);
        end
    endtask

    task automatic m_cipher(input bit dec, input logic [15:0] t, input logic [31:0] key,
                            output logic [15:0] res);
        int rk [R+1];
        int s = int'(t);
        m_keys(key, rk);
        if (!dec) begin
            for (int r = 0; r < R; r++) s = m_perm(m_sub(s ^ rk[r], 1'b0), 1'b0);
            s ^= rk[R];
        end else begin
            s ^= rk[R];
            for (int r = R - 1; r >= 0; r--) s = m_sub(m_perm(s, 1'b1), 1'b1) ^ rk[r];
        end
        res = 16'(s);
    endtask

    task automatic run_op(input bit m, input logic [15:0] t, input logic [31:0] k,
                          input int stall, output logic [15:0] res);
        logic [15:0] exp;
        int lat = 0;
        int n = 0;
        int exp_lat;
        bit hit = 1'b0;
        m_cipher(m, t, k, exp);
`ifdef PRESENT_KEYCACHE_EN
        hit = m && c_vld && (c_key == k);
`endif
        exp_lat = (!m || hit) ? R + 1 : 2 * R + 1;
        res = 16'h0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("ready_wait", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_mode = m; in_text = t; in_key = k;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_mode = 1'($urandom); in_text = 16'($urandom); in_key = $urandom;
        while (!out_valid && lat < 100) begin
            check("ready_low", {31'h0, in_ready}, 32'h0);
            check("busy_high", {31'h0, busy}, 32'h1);
            in_valid = ($urandom % 3 == 0);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("timeout", {31'h0, out_valid}, 32'h1);
            return;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", {16'h0, out_text}, {16'h0, exp});
        res = out_text;
        if (m && !hit) begin c_vld = 1'b1; c_key = k; end
        for (int i = 0; i < stall; i++) begin
            in_valid = i[0];
            in_text = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_text", {16'h0, out_text}, {16'h0, exp});
            check("hold_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", {31'h0, out_valid}, 32'h0);
        check("drain_ready", {31'h0, in_ready}, 32'h1);
        check("drain_busy", {31'h0, busy}, 32'h0);
        out_ready = 1'($urandom);
    endtask

    initial begin
        logic [15:0] r1, r2, t;
        logic [31:0] k;
        bit m;
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
        in_text = 16'h0; in_key = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_text", {16'h0, out_text}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;

        run_op(1'b0, 16'h0000, 32'h00000000, 0, r1);
        run_op(1'b1, r1, 32'h00000000, 0, r2);
        check("rt_zero", {16'h0, r2}, 32'h0);
        run_op(1'b0, 16'hBEEF, 32'hDEADC0DE, 0, r1);
        run_op(1'b1, r1, 32'hDEADC0DE, 2, r2);
        check("rt_beef", {16'h0, r2}, 32'h0000BEEF);
        run_op(1'b0, 16'h1234, 32'hA5A5F00F, 5, r1);

        // Abort an encrypt three cycles in
        while (!in_ready) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_mode = 1'b0; in_text = 16'h5555; in_key = 32'h01020304;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        c_vld = 1'b0;
        check("abort_ready", {31'h0, in_ready}, 32'h1);
        check("abort_text", {16'h0, out_text}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("abort_novalid", {31'h0, out_valid}, 32'h0);
        end
        run_op(1'b0, 16'h5555, 32'h01020304, 1, r1);

        run_op(1'b1, 16'hC0DE, 32'h12345678, 0, r1);
        run_op(1'b1, 16'hC0DE, 32'h12345678, 1, r2);
        check("cache_same", {16'h0, r2}, {16'h0, r1});
        run_op(1'b1, 16'hC0DE, 32'h12345679, 0, r2);

        for (int i = 0; i < 200; i++) begin
            m = 1'($urandom);
            t = 16'($urandom);
            k = ($urandom % 4 == 0) ? c_key : $urandom;
            run_op(m, t, k, int'($urandom % 4), r1);
            if (!m) begin
                run_op(1'b1, r1, k, int'($urandom % 3), r2);
                check("rt_rand", {16'h0, r2}, {16'h0, t});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
